// File: rtl/elevator_car_fsm.sv
// -----------------------------------------------------------------------------
// elevator_car_fsm
//
// Motion and door controller for a single elevator car. It reads the per-car
// request queue (one bit per floor), picks a travel direction with SCAN
// ordering (keep going the way we last went while requests remain that way),
// steps the car one floor per TRAVEL_CYCLES, opens the door at every
// requested floor and writes a one-cycle clear back to the queue for the
// served floor.
//
// Optional feature macro: ELEVATOR_CAR_DOOR_HOLD_EN
//   defined   -> door_hold input exists; while high in DOOR the door timer is
//                held at zero, so the door closes DOOR_CYCLES after it falls.
//   undefined -> no door_hold port; the door is open for exactly DOOR_CYCLES
//                after the ARRIVE cycle.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   queue_status      pending requests, bit i = floor i
//   q_r_nwr           queue access: 1 = read/refresh, 0 = write
//   q_deassert_floor  queue write type: 1 = clear the addressed bit
//   q_floor           queue address (always the current floor)
//   current_floor     floor the car is at or last passed
//   moving_up         car travelling upward
//   moving_down       car travelling downward
//   door_open         door open (ARRIVE and DOOR)
//   door_hold         keep door open (only with ELEVATOR_CAR_DOOR_HOLD_EN)
//
// All outputs are registered: they are decoded from the next state and
// flopped, so they line up with the state register cycle for cycle.
// -----------------------------------------------------------------------------
module elevator_car_fsm #(
    parameter int FLOOR_COUNT   = 7,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FLOOR_COUNT-1:0] queue_status,
`ifdef ELEVATOR_CAR_DOOR_HOLD_EN
    input  logic                   door_hold,
`endif
    output logic                   q_r_nwr,
    output logic                   q_deassert_floor,
    output logic [2:0]             q_floor,
    output logic [2:0]             current_floor,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   door_open
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVE_UP   = 3'd1,
        S_MOVE_DOWN = 3'd2,
        S_ARRIVE    = 3'd3,
        S_DOOR      = 3'd4
    } state_t;

    // Any request strictly above the given floor (only existing floors are scanned).
    function automatic logic any_above(input logic [FLOOR_COUNT-1:0] st, input logic [2:0] fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            r = r | (st[i] & (3'(i) > fl));
        end
        return r;
    endfunction

    // Any request strictly below the given floor.
    function automatic logic any_below(input logic [FLOOR_COUNT-1:0] st, input logic [2:0] fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            r = r | (st[i] & (3'(i) < fl));
        end
        return r;
    endfunction

    // Request bit for a floor; an index past the top floor reads as 0 instead of
    // addressing a bit that does not exist.
    function automatic logic bit_at(input logic [FLOOR_COUNT-1:0] st, input logic [2:0] fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            r = r | (st[i] & (3'(i) == fl));
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    floor_q, floor_d;
    logic          dir_up_q, dir_up_d;     // last_dir: 1 = up, 0 = down
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          q_r_nwr_q, q_r_nwr_d;
    logic          q_deassert_q, q_deassert_d;
    logic [2:0]    q_floor_q, q_floor_d;
    logic          moving_up_q, moving_up_d;
    logic          moving_down_q, moving_down_d;
    logic          door_open_q, door_open_d;
    logic          door_hold_s;

`ifdef ELEVATOR_CAR_DOOR_HOLD_EN
    assign door_hold_s = door_hold;
`else
    assign door_hold_s = 1'b0;
`endif

    // Next-state, counters and registered-output decode.
    always_comb begin
        logic [2:0] nxt_up;
        logic [2:0] nxt_dn;
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        nxt_up   = floor_q + 3'd1;
        nxt_dn   = floor_q - 3'd1;

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                dcnt_d = '0;
                if (bit_at(queue_status, floor_q)) begin
                    state_d = S_ARRIVE;
                end else if (dir_up_q && any_above(queue_status, floor_q)) begin
                    state_d  = S_MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (any_below(queue_status, floor_q)) begin
                    state_d  = S_MOVE_DOWN;
                    dir_up_d = 1'b0;
                end else if (any_above(queue_status, floor_q)) begin
                    state_d  = S_MOVE_UP;
                    dir_up_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MOVE_UP: begin
                if (tcnt_q == TRAVEL_LAST) begin
                    tcnt_d  = '0;
                    floor_d = nxt_up;
                    if (bit_at(queue_status, nxt_up)) begin
                        state_d = S_ARRIVE;
                    end else if (any_above(queue_status, nxt_up)) begin
                        state_d = S_MOVE_UP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_MOVE_DOWN: begin
                if (tcnt_q == TRAVEL_LAST) begin
                    tcnt_d  = '0;
                    floor_d = nxt_dn;
                    if (bit_at(queue_status, nxt_dn)) begin
                        state_d = S_ARRIVE;
                    end else if (any_below(queue_status, nxt_dn)) begin
                        state_d = S_MOVE_DOWN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_ARRIVE: begin
                state_d = S_DOOR;
                dcnt_d  = '0;
            end
            S_DOOR: begin
                if (door_hold_s) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DOOR_LAST) begin
                    dcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tcnt_d  = '0;
                dcnt_d  = '0;
            end
        endcase

        q_r_nwr_d     = (state_d != S_ARRIVE);
        q_deassert_d  = (state_d == S_ARRIVE);
        q_floor_d     = floor_d;
        moving_up_d   = (state_d == S_MOVE_UP);
        moving_down_d = (state_d == S_MOVE_DOWN);
        door_open_d   = (state_d == S_ARRIVE) || (state_d == S_DOOR);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            floor_q       <= 3'd0;
            dir_up_q      <= 1'b1;
            tcnt_q        <= '0;
            dcnt_q        <= '0;
            q_r_nwr_q     <= 1'b1;
            q_deassert_q  <= 1'b0;
            q_floor_q     <= 3'd0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            floor_q       <= floor_d;
            dir_up_q      <= dir_up_d;
            tcnt_q        <= tcnt_d;
            dcnt_q        <= dcnt_d;
            q_r_nwr_q     <= q_r_nwr_d;
            q_deassert_q  <= q_deassert_d;
            q_floor_q     <= q_floor_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
            door_open_q   <= door_open_d;
        end
    end

    assign q_r_nwr          = q_r_nwr_q;
    assign q_deassert_floor = q_deassert_q;
    assign q_floor          = q_floor_q;
    assign current_floor    = floor_q;
    assign moving_up        = moving_up_q;
    assign moving_down      = moving_down_q;
    assign door_open        = door_open_q;

endmodule
